// File: rtl/alu_seq_psr.sv
// alu_seq_psr: clocked ALU with a valid/ready request/response handshake and
// its own 5-bit processor status register {C,L,F,Z,N}.
//
// Ports:
//   clk, reset_n        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   op, use_imm, a, b, imm   request payload (op codes listed below)
//   out_valid/out_ready response handshake; result is held until consumed
//   result              registered result
//   psr                 status flags, bits 4..0 = C,L,F,Z,N
//   psr_wr, psr_wdata   direct PSR load; takes priority over any commit
//   busy                an iterative op (shift, multiply) is running
//
// Op codes: 0 AND, 1 OR, 2 XOR, 3 MOV, 4 ADD, 5 ADDU, 6 ADDC, 7 SUB, 8 SUBC,
// 9 CMP, 10 LSH, 11 ASH, 12 LUI, 13 MUL, 14/15 illegal (result 0).
module alu_seq_psr #(
  parameter int WIDTH   = 16,
  parameter int IMM_W   = 8,
  parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             use_imm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [IMM_W-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       psr,
  input  logic             psr_wr,
  input  logic [4:0]       psr_wdata,
  output logic             busy
);

  // Counter must hold both a shift magnitude and the WIDTH multiply steps.
  localparam int CNT_W = (SHAMT_W > $clog2(WIDTH + 1)) ? SHAMT_W : $clog2(WIDTH + 1);
  localparam int MSB   = WIDTH - 1;

  localparam int PSR_C = 4;
  localparam int PSR_L = 3;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 1;
  localparam int PSR_N = 0;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,  OP_OR   = 4'd1,  OP_XOR  = 4'd2,  OP_MOV  = 4'd3,
    OP_ADD  = 4'd4,  OP_ADDU = 4'd5,  OP_ADDC = 4'd6,  OP_SUB  = 4'd7,
    OP_SUBC = 4'd8,  OP_CMP  = 4'd9,  OP_LSH  = 4'd10, OP_ASH  = 4'd11,
    OP_LUI  = 4'd12, OP_MUL  = 4'd13, OP_I14  = 4'd14, OP_I15  = 4'd15
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic [4:0]         psr_q, psr_d;

  op_t                op_in;
  logic               accept;
  logic               imm_signed;
  logic [WIDTH-1:0]   imm_sx, imm_zx, b_sel;
  logic [SHAMT_W-1:0] amt_raw, amt_mag;
  logic               add_cin, sub_bin;
  logic [WIDTH:0]     add_full, sub_full;
  logic               add_ovf, sub_ovf, lt_u, lt_s, eq;
  logic [WIDTH-1:0]   alu_res;
  logic [4:0]         alu_psr;
  logic [WIDTH:0]     mul_sum;
  logic               shr_fill;
  logic [2*WIDTH-1:0] acc_step;

  assign op_in     = op_t'(op);
  assign in_ready  = reset_n & (state_q == S_IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_EXEC);
  assign result    = result_q;
  assign psr       = psr_q;

  // Immediate extension depends on the op; shifts are sign-extended so a
  // narrow immediate still reads as a signed amount in its low bits.
  always_comb begin
    imm_signed = 1'b0;
    case (op_in)
      OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_MUL,
      OP_LSH, OP_ASH: imm_signed = 1'b1;
      default:        imm_signed = 1'b0;
    endcase
  end

  assign imm_sx = WIDTH'($signed(imm));
  assign imm_zx = WIDTH'(imm);
  assign b_sel  = use_imm ? (imm_signed ? imm_sx : imm_zx) : b;

  // Signed shift amount: negative means shift right.
  assign amt_raw = b_sel[SHAMT_W-1:0];
  assign amt_mag = amt_raw[SHAMT_W-1] ? ((~amt_raw) + SHAMT_W'(1)) : amt_raw;

  assign add_cin  = (op_in == OP_ADDC) & psr_q[PSR_C];
  assign sub_bin  = (op_in == OP_SUBC) & psr_q[PSR_C];
  assign add_full = {1'b0, a} + {1'b0, b_sel} + {{WIDTH{1'b0}}, add_cin};
  assign sub_full = {1'b0, a} - {1'b0, b_sel} - {{WIDTH{1'b0}}, sub_bin};
  assign add_ovf  = (a[MSB] == b_sel[MSB]) && (add_full[MSB] != a[MSB]);
  assign sub_ovf  = (a[MSB] != b_sel[MSB]) && (sub_full[MSB] != a[MSB]);
  assign lt_u     = a < b_sel;
  assign lt_s     = $signed(a) < $signed(b_sel);
  assign eq       = (a == b_sel);

  // Single-cycle result and the PSR it would commit.
  always_comb begin
    alu_res = '0;
    alu_psr = psr_q;
    case (op_in)
      OP_AND:  alu_res = a & b_sel;
      OP_OR:   alu_res = a | b_sel;
      OP_XOR:  alu_res = a ^ b_sel;
      OP_MOV:  alu_res = b_sel;
      OP_ADD, OP_ADDC: begin
        alu_res        = add_full[WIDTH-1:0];
        alu_psr[PSR_C] = add_full[WIDTH];
        alu_psr[PSR_F] = add_ovf;
      end
      OP_ADDU: alu_res = add_full[WIDTH-1:0];
      OP_SUB, OP_SUBC: begin
        alu_res        = sub_full[WIDTH-1:0];
        alu_psr[PSR_C] = sub_full[WIDTH];
        alu_psr[PSR_L] = lt_u;
        alu_psr[PSR_F] = sub_ovf;
        alu_psr[PSR_Z] = (sub_full[WIDTH-1:0] == '0);
        alu_psr[PSR_N] = lt_s;
      end
      OP_CMP: begin
        alu_psr[PSR_L] = lt_u;
        alu_psr[PSR_Z] = eq;
        alu_psr[PSR_N] = lt_s;
      end
      OP_LSH, OP_ASH: alu_res = a;  // zero-amount shift
      OP_LUI:  alu_res = WIDTH'(b_sel[IMM_W-1:0]) << (WIDTH - IMM_W);
      default: alu_res = '0;
    endcase
  end

  // One iteration step. MUL keeps the product in acc: the high half
  // accumulates the multiplicand, the low half holds the remaining
  // multiplier bits and shifts right each step. Shifts use the low half only.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    shr_fill = (op_q == OP_ASH) & acc_q[MSB];
    if (op_q == OP_MUL)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (left_q)
      acc_step = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
    else
      acc_step = {acc_q[2*WIDTH-1:WIDTH], shr_fill, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    psr_d    = psr_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d = op_in;
          case (op_in)
            OP_LSH, OP_ASH: begin
              if (amt_mag == '0) begin
                state_d  = S_DONE;
                result_d = a;
              end else begin
                state_d = S_EXEC;
                acc_d   = {{WIDTH{1'b0}}, a};
                cnt_d   = CNT_W'(amt_mag);
                left_d  = ~amt_raw[SHAMT_W-1];
              end
            end
            OP_MUL: begin
              state_d = S_EXEC;
              acc_d   = {{WIDTH{1'b0}}, b_sel};
              mcand_d = a;
              cnt_d   = CNT_W'(WIDTH);
            end
            default: begin
              state_d  = S_DONE;
              result_d = alu_res;
              psr_d    = alu_psr;
            end
          endcase
        end
      end
      S_EXEC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          result_d = acc_step[WIDTH-1:0];
          if (op_q == OP_MUL)
            psr_d[PSR_C] = |acc_step[2*WIDTH-1:WIDTH];
        end
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Context restore overrides any same-cycle commit.
    if (psr_wr)
      psr_d = psr_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      result_q <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      psr_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      psr_q    <= psr_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_psr.sv
// Testbench for alu_seq_psr: a chained table of ops (PSR expectations carry
// from one entry to the next) plus hand-written reset and PSR-load sequences.
module tb_alu_seq_psr;
  localparam int W  = 16;
  localparam int IW = 8;

  localparam logic [3:0] AND_ = 4'd0,  OR_  = 4'd1,  XOR_ = 4'd2,  MOV_ = 4'd3;
  localparam logic [3:0] ADD_ = 4'd4,  ADDU = 4'd5,  ADDC = 4'd6,  SUB_ = 4'd7;
  localparam logic [3:0] SUBC = 4'd8,  CMP_ = 4'd9,  LSH_ = 4'd10, ASH_ = 4'd11;
  localparam logic [3:0] LUI_ = 4'd12, MUL_ = 4'd13, ILL_ = 4'd14;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, in_ready, use_imm, out_valid, out_ready;
  logic          psr_wr, busy;
  logic [3:0]    op;
  logic [W-1:0]  a, b, result;
  logic [IW-1:0] imm;
  logic [4:0]    psr, psr_wdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_psr #(.WIDTH(W), .IMM_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .use_imm(use_imm), .a(a), .b(b), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .psr(psr),
    .psr_wr(psr_wr), .psr_wdata(psr_wdata), .busy(busy)
  );

  typedef struct {
    logic [3:0]    op;
    logic          ui;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [IW-1:0] imm;
    logic [W-1:0]  res;
    logic [4:0]    psr;
    int            lat;
    int            bsy;
    int            hold;
  } vec_t;

  typedef struct {
    logic [W-1:0] res;
    logic [4:0]   psr;
    int           lat;
    int           bsy;
    int           id;
  } exp_t;

  vec_t vt[$];
  exp_t sbq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h, expected %0h", nm, id, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   t;
    int   lat;
    int   bc;
    exp_t e;
    t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    if (!in_ready) begin
      chk("in_ready_wait", id, in_ready, 1);
      return;
    end
    op = v.op; use_imm = v.ui; a = v.a; b = v.b; imm = v.imm;
    in_valid = 1'b1; out_ready = 1'b0;
    sbq.push_back('{res: v.res, psr: v.psr, lat: v.lat, bsy: v.bsy, id: id});
    step();
    in_valid = 1'b0;
    lat = 1; bc = 0;
    while (!out_valid && lat < 60) begin
      if (busy) bc++;
      step();
      lat++;
    end
    if (!out_valid) begin
      chk("timeout", id, out_valid, 1);
      sbq.delete();
      return;
    end
    e = sbq.pop_front();
    chk("result", e.id, result, e.res);
    chk("psr", e.id, psr, e.psr);
    chk("latency", e.id, lat, e.lat);
    chk("busy_cycles", e.id, bc, e.bsy);
    for (int i = 0; i < v.hold; i++) begin
      step();
      chk("hold_result", e.id, result, e.res);
      chk("hold_valid", e.id, out_valid, 1);
      chk("hold_in_ready", e.id, in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("drained", e.id, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_imm = 1'b0;
    op = '0; a = '0; b = '0; imm = '0; psr_wr = 1'b0; psr_wdata = '0;

    //              op    ui    a        b        imm     res      psr       lat bsy hold
    vt.push_back('{ADD_, 1'b0, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 5'b00100, 1,  0,  0});
    vt.push_back('{ADDC, 1'b0, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 5'b10000, 1,  0,  0});
    vt.push_back('{ADDC, 1'b0, 16'h0000, 16'h0000, 8'h00, 16'h0001, 5'b00000, 1,  0,  0});
    vt.push_back('{SUB_, 1'b1, 16'h0003, 16'h0000, 8'hFF, 16'h0004, 5'b11000, 1,  0,  0});
    vt.push_back('{CMP_, 1'b0, 16'h1234, 16'h1234, 8'h00, 16'h0000, 5'b10010, 1,  0,  0});
    vt.push_back('{LSH_, 1'b1, 16'h8001, 16'h0000, 8'h1D, 16'h1000, 5'b10010, 4,  3,  0});
    vt.push_back('{ASH_, 1'b0, 16'h8000, 16'hFFF0, 8'h00, 16'hFFFF, 5'b10010, 17, 16, 0});
    vt.push_back('{ADD_, 1'b0, 16'h0001, 16'h0001, 8'h00, 16'h0002, 5'b00010, 1,  0,  0});
    vt.push_back('{MUL_, 1'b0, 16'h0100, 16'h0100, 8'h00, 16'h0000, 5'b10010, 17, 16, 5});
    vt.push_back('{ADDU, 1'b0, 16'hFFFF, 16'h0002, 8'h00, 16'h0001, 5'b10010, 1,  0,  0});
    vt.push_back('{LSH_, 1'b0, 16'h0003, 16'h0004, 8'h00, 16'h0030, 5'b10010, 5,  4,  0});
    vt.push_back('{LSH_, 1'b1, 16'hABCD, 16'h0000, 8'h00, 16'hABCD, 5'b10010, 1,  0,  0});
    vt.push_back('{LSH_, 1'b0, 16'hFFFF, 16'h0010, 8'h00, 16'h0000, 5'b10010, 17, 16, 0});
    vt.push_back('{XOR_, 1'b0, 16'hF0F0, 16'hFF00, 8'h00, 16'h0FF0, 5'b10010, 1,  0,  0});
    vt.push_back('{MOV_, 1'b1, 16'h1111, 16'h2222, 8'h80, 16'h0080, 5'b10010, 1,  0,  0});
    vt.push_back('{LUI_, 1'b1, 16'h1111, 16'h2222, 8'hAB, 16'hAB00, 5'b10010, 1,  0,  0});
    vt.push_back('{ILL_, 1'b0, 16'h1234, 16'h5678, 8'h00, 16'h0000, 5'b10010, 1,  0,  0});
    vt.push_back('{SUB_, 1'b0, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 5'b00101, 1,  0,  0});
    vt.push_back('{SUBC, 1'b0, 16'h0005, 16'h0002, 8'h00, 16'h0003, 5'b00000, 1,  0,  0});
    vt.push_back('{SUB_, 1'b0, 16'h0000, 16'h0001, 8'h00, 16'hFFFF, 5'b11001, 1,  0,  0});
    vt.push_back('{SUBC, 1'b0, 16'h0005, 16'h0002, 8'h00, 16'h0002, 5'b00000, 1,  0,  0});
    vt.push_back('{MUL_, 1'b0, 16'h0012, 16'h0034, 8'h00, 16'h03A8, 5'b00000, 17, 16, 0});
    vt.push_back('{ASH_, 1'b0, 16'h4001, 16'h0001, 8'h00, 16'h8002, 5'b00000, 2,  1,  0});
    vt.push_back('{ASH_, 1'b1, 16'h8004, 16'h0000, 8'h1E, 16'hE001, 5'b00000, 3,  2,  0});
    vt.push_back('{ADD_, 1'b0, 16'hFFFF, 16'h0002, 8'h00, 16'h0001, 5'b10000, 1,  0,  0});
    vt.push_back('{ADDC, 1'b1, 16'h0010, 16'h0000, 8'hFF, 16'h0010, 5'b10000, 1,  0,  0});
    vt.push_back('{AND_, 1'b0, 16'hFF0F, 16'h0F0F, 8'h00, 16'h0F0F, 5'b10000, 1,  0,  0});
    vt.push_back('{OR_,  1'b1, 16'h1200, 16'h0000, 8'h34, 16'h1234, 5'b10000, 1,  0,  0});
    vt.push_back('{ADD_, 1'b1, 16'h0000, 16'h0000, 8'h80, 16'hFF80, 5'b00000, 1,  0,  0});

    // Reset state.
    step();
    chk("rst_in_ready", 0, in_ready, 0);
    step();
    chk("rst_result", 0, result, 0);
    chk("rst_psr", 0, psr, 0);
    chk("rst_out_valid", 0, out_valid, 0);
    chk("rst_busy", 0, busy, 0);
    reset_n = 1'b1;
    #1;
    chk("rst_release_ready", 0, in_ready, 1);

    foreach (vt[i]) run_vec(vt[i], i);

    // PSR load in the same cycle as an ADD commit: the load wins.
    op = ADD_; use_imm = 1'b0; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    psr_wr = 1'b1; psr_wdata = 5'b10101;
    step();
    in_valid = 1'b0; psr_wr = 1'b0;
    chk("psrwr_valid", 100, out_valid, 1);
    chk("psrwr_result", 100, result, 16'h0002);
    chk("psrwr_psr", 100, psr, 5'b10101);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    run_vec('{AND_, 1'b1, 16'hFFFF, 16'h0000, 8'h80, 16'h0080, 5'b10101, 1, 0, 0}, 101);

    // Reset during a running multiply discards it and clears the PSR.
    op = MUL_; use_imm = 1'b0; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_mul_busy", 102, busy, 1);
    reset_n = 1'b0;
    step();
    chk("mid_mul_out_valid", 102, out_valid, 0);
    chk("mid_mul_psr", 102, psr, 0);
    chk("mid_mul_busy_clr", 102, busy, 0);
    chk("mid_mul_in_ready_rst", 102, in_ready, 0);
    reset_n = 1'b1;
    #1;
    chk("mid_mul_in_ready", 102, in_ready, 1);
    // Carry was cleared by reset, so ADDC adds nothing extra.
    run_vec('{ADDC, 1'b0, 16'h0000, 16'h0000, 8'h00, 16'h0000, 5'b00000, 1, 0, 0}, 103);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_psr.md
Name: alu_seq_psr

Overview:
- Parametrised, clocked successor to the combinational datapath ALU.
- Accepts one operation at a time over a valid/ready handshake and registers the result.
- Owns the 5-bit processor status register (PSR) in CLFZN order, so ADDC/SUBC chain through the stored carry.
- Runs shifts and multiply iteratively over several cycles. Sits between the register-file read stage and writeback.

Parameters:
WIDTH, 16, datapath width in bits (must be ≥ 8 and ≥ IMM_W).
IMM_W, 8, immediate field width.
SHAMT_W, $clog2(WIDTH)+1, width of the signed shift-amount field taken from the low bits of the B operand or immediate.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
in_valid  in  1  request valid
in_ready  out  1  block can accept a request
op  in  4  operation select (see Behaviour)
use_imm  in  1  1 = second operand comes from imm, not b
a  in  WIDTH  operand A
b  in  WIDTH  operand B
imm  in  IMM_W  immediate
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
psr  out  5  flags {C,L,F,Z,N} = bits 4..0
psr_wr  in  1  direct PSR load (context restore)
psr_wdata  in  5  value for psr_wr
busy  out  1  iterative op in progress

Behaviour:
- Reset, on a clk edge with reset_n=0: state=IDLE, result=0, psr=0, out_valid=0, busy=0. in_ready=0 while reset_n=0. Any in-flight op is discarded.
- FSM states: IDLE, EXEC, DONE.
  - in_ready=1 only in IDLE.
  - An accept (in_valid & in_ready) captures op, operands and the extended immediate.
  - Single-cycle ops: IDLE→DONE. result and out_valid appear the cycle after the accept (latency 1).
  - Iterative ops: IDLE→EXEC, with busy=1 in EXEC. EXEC→DONE when the iteration count expires.
  - DONE: result and out_valid hold steady until out_ready=1, then DONE→IDLE.
- Throughput is at most 1 op per 2 cycles. Inputs other than psr_wr and psr_wdata are ignored outside IDLE.
- Immediate extension:
  - Sign-extended for ADD, ADDU, ADDC, SUB, SUBC, CMP, MUL.
  - Zero-extended for AND, OR, XOR, MOV.
  - Shifts use the low SHAMT_W bits as a signed amount.
- Ops (B' = selected second operand):
  - 0 AND, 1 OR, 2 XOR, 3 MOV (result=B').
  - 4 ADD: result=A+B'. Updates C (carry out) and F (signed overflow).
  - 5 ADDU: result=A+B'. PSR unchanged.
  - 6 ADDC: result=A+B'+psr.C. Updates C and F.
  - 7 SUB: result=A−B'. Updates all five flags: C=borrow (A<B' unsigned), L=A<B' unsigned, F=signed overflow, Z=result==0, N=A<B' signed.
  - 8 SUBC: result=A−B'−psr.C. Updates the same five flags as SUB.
  - 9 CMP: result=0. Updates L, Z (A==B') and N as for SUB; C and F unchanged.
  - 10 LSH: logical shift. 11 ASH: arithmetic shift.
    - Positive amount = left, negative = right.
    - Iterative, one bit per cycle: latency |amt|+1, and amt=0 has latency 1.
    - A right shift by WIDTH gives 0 for LSH and sign-fill for ASH.
  - 12 LUI: result = B'[IMM_W−1:0] placed in the top bits, zero-filled below.
  - 13 MUL: unsigned shift-add, exactly WIDTH EXEC cycles (latency WIDTH+1). result = low WIDTH bits; C=1 if the high half is nonzero; other flags unchanged.
  - 14, 15 illegal: result=0, PSR unchanged, latency 1.
- Flags not listed for an op are preserved.
- PSR commit timing: written on the IDLE→DONE or EXEC→DONE transition, so the next ADDC/SUBC sees the updated carry.
- If psr_wr coincides with a commit, psr_wr wins.
- All arithmetic wraps modulo 2^WIDTH.

Test Plan:
- Reset mid-MUL (reset_n low during EXEC) → next cycle out_valid=0, psr=0, in_ready=1 after release.
- ADD a=0x7FFF, b=0x0001 → result 0x8000, psr.F=1, psr.C=0, latency 1. Then ADDC a=0xFFFF, b=0x0001 → result 0x0000, C=1. Then ADDC a=0, b=0 → result 0x0001.
- SUB a=0x0003, use_imm imm=0xFF (−1) → result 0x0004. psr: C=1, L=1, Z=0, N=0. Then CMP a=0x1234, b=0x1234 → result 0, Z=1, L=0, N=0, with C/F preserved.
- LSH a=0x8001, imm=0x1D (−3) → result 0x1000, busy high 3 cycles, latency 4. ASH a=0x8000, b=−16 → result 0xFFFF.
- MUL a=0x0100, b=0x0100 → result 0x0000, C=1, out_valid exactly 17 cycles after accept. Hold out_ready=0 for 5 cycles → result stable and in_ready=0 throughout.
- psr_wr=1, psr_wdata=5'b10101 in the same cycle as an ADD commit → psr=5'b10101. ANDI a=0xFFFF, imm=0x80 → result 0x0080 (zero-extended), psr unchanged.
